fetch_unit: RTL and testbench

Parametrised program-counter / fetch unit for the processor front end. It is the next generation of the team's 7-bit fetch block and adds:
- configurable PC and offset widths
- absolute jumps
- a call/return stack with overflow/underflow flags
- a sticky halt state machine

It drives the instruction-memory address and takes branch, jump, call and return requests from decode/execute.

---
 rtl/fetch_pkg.sv | 31 +++
 rtl/fetch_if.sv | 42 ++++
 rtl/fetch_ras.sv | 83 ++++++++
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and helpers for the fetch unit and its return-address stack.
//   fetch_state_t : IDLE / RUN / HALTED front-end state
//   pc_src_t      : which source the next PC was taken from. It drives the
//                   next-PC mux and is easy to observe in a waveform.
//   ptr_width()   : index width for a power-of-two array, never below 1 bit
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef enum logic [2:0] {
    SRC_HOLD   = 3'd0,  // pc keeps its value (idle, halted, or halt request)
    SRC_START  = 3'd1,  // start_address
    SRC_RET    = 3'd2,  // popped return address
    SRC_CALL   = 3'd3,  // call target
    SRC_JUMP   = 3'd4,  // jump target
    SRC_BRANCH = 3'd5,  // pc + sign-extended offset
    SRC_INC    = 3'd6   // pc + 1. This includes a ret issued on an empty stack.
  } pc_src_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// -----------------------------------------------------------------------------
// fetch_if
// Request/response bundle between decode/execute and the fetch unit.
//   Requests (master -> slave): start, start_address, branch, taken, offset,
//                               jump, call, ret, target, halt
//   Status   (slave -> master): pc, running, ras_overflow, ras_underflow
// Clock and reset are not part of the bundle. They stay plain ports.
// -----------------------------------------------------------------------------
interface fetch_if #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned OFF_W = 5
);

  logic              start;
  logic [PC_W-1:0]   start_address;
  logic              branch;
  logic              taken;
  logic [OFF_W-1:0]  offset;
  logic              jump;
  logic              call;
  logic              ret;
  logic [PC_W-1:0]   target;
  logic              halt;

  logic [PC_W-1:0]   pc;
  logic              running;
  logic              ras_overflow;
  logic              ras_underflow;

  modport master (
    output start, start_address, branch, taken, offset,
           jump, call, ret, target, halt,
    input  pc, running, ras_overflow, ras_underflow
  );

  modport slave (
    input  start, start_address, branch, taken, offset,
           jump, call, ret, target, halt,
    output pc, running, ras_overflow, ras_underflow
  );

endinterface

// File: rtl/fetch_ras.sv
// -----------------------------------------------------------------------------
// fetch_ras
// Circular return-address stack.
//   clock, reset_n : clock and asynchronous active-low reset. Reset clears the
//                    pointer and count only. Entry contents are don't-care.
//   push/push_data : write an entry. When the stack is full the write lands on
//                    the oldest entry and count stays at RAS_DEPTH.
//   pop/pop_data   : pop_data always shows the top entry combinationally, so
//                    the caller can use it on the same edge as the pop.
//   clear          : drop all entries. Clear has priority over pop and push.
//   empty, full    : occupancy status.
// Pop wins over push. A pop on an empty stack is ignored.
// -----------------------------------------------------------------------------
module fetch_ras
  import fetch_pkg::*;
#(
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned PC_W      = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] pop_data,
  output logic            empty,
  output logic            full
);

  localparam int unsigned PTR_W = ptr_width(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_W-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d;      // next slot to write
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_idx;
  logic             pop_en;
  logic             push_en;

  // Depth is a power of two, so pointer arithmetic wraps around the array
  // naturally. When the stack is full, top_q points at the oldest entry.
  assign rd_idx   = top_q - PTR_W'(1);
  assign pop_data = mem_q[rd_idx];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(RAS_DEPTH));
  assign pop_en   = pop && !clear && !empty;
  assign push_en  = push && !clear && !pop_en;

  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    if (clear) begin
      top_d   = '0;
      count_d = '0;
    end else if (pop_en) begin
      top_d   = rd_idx;
      count_d = count_q - CNT_W'(1);
    end else if (push_en) begin
      top_d = top_q + PTR_W'(1);
      if (!full) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      top_q   <= '0;
      count_q <= '0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_en) begin
      mem_q[top_q] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Program counter and fetch control for the processor front end.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset (pc=0, IDLE, flags clear)
//   bus     : fetch_if slave. It carries the start/branch/jump/call/ret/halt
//             requests in, and pc, running and the sticky stack flags out.
// Next-PC priority in RUN: start > ret > call > jump > taken branch > halt > +1.
// OFF_W must not exceed PC_W. RAS_DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned OFF_W     = 5,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic  clock,
  input  logic  reset_n,
  fetch_if.slave bus
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  pc_src_t         pc_src;
  logic            running;

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] offset_ext;
  logic [PC_W-1:0] ras_pop_data;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_push;
  logic            ras_pop;
  logic            ret_underflow;

  assign pc_inc     = pc_q + PC_W'(1);
  assign offset_ext = PC_W'($signed(bus.offset));

  // Choose the next-PC source. Only start is honoured outside RUN.
  always_comb begin
    pc_src = SRC_HOLD;
    if (bus.start) begin
      pc_src = SRC_START;
    end else if (state_q == RUN) begin
      if (bus.ret)                      pc_src = ras_empty ? SRC_INC : SRC_RET;
      else if (bus.call)                pc_src = SRC_CALL;
      else if (bus.jump)                pc_src = SRC_JUMP;
      else if (bus.branch && bus.taken) pc_src = SRC_BRANCH;
      else if (bus.halt)                pc_src = SRC_HOLD;
      else                              pc_src = SRC_INC;
    end
  end

  always_comb begin
    pc_d = pc_q;
    case (pc_src)
      SRC_START:  pc_d = bus.start_address;
      SRC_RET:    pc_d = ras_pop_data;
      SRC_CALL:   pc_d = bus.target;
      SRC_JUMP:   pc_d = bus.target;
      SRC_BRANCH: pc_d = pc_q + offset_ext;
      SRC_INC:    pc_d = pc_inc;
      default:    pc_d = pc_q;
    endcase
  end

  // Return-address stack control. A call paired with a ret never reaches
  // SRC_CALL, so that call is dropped without a push.
  assign ras_push      = (pc_src == SRC_CALL);
  assign ras_pop       = (pc_src == SRC_RET);
  assign ret_underflow = !bus.start && (state_q == RUN) && bus.ret && ras_empty;

  fetch_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .PC_W      (PC_W)
  ) u_ras (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .clear     (bus.start),
    .push_data (pc_inc),
    .pop_data  (ras_pop_data),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // FSM next state. In RUN, SRC_HOLD can only come from a halt request that
  // no higher-priority request overrode.
  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = RUN;
    end else if ((state_q == RUN) && (pc_src == SRC_HOLD)) begin
      state_d = HALTED;
    end
  end

  // FSM output
  always_comb begin
    running = (state_q == RUN);
  end

  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (bus.start) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (ras_push && ras_full) ovf_d = 1'b1;
      if (ret_underflow)        unf_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.running       = running;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit with PC_W=8, OFF_W=5, RAS_DEPTH=4.
// Each step drives requests, queues the expected pc/running/flags, waits one
// clock edge, then pops the queued expectation and compares it to the outputs.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int unsigned PC_W      = 8;
  localparam int unsigned OFF_W     = 5;
  localparam int unsigned RAS_DEPTH = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  fetch_if #(.PC_W(PC_W), .OFF_W(OFF_W)) bus ();

  fetch_unit #(
    .PC_W      (PC_W),
    .OFF_W     (OFF_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [7:0] pc;
    logic       run;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_state(input string tag, input logic [7:0] pc,
                              input logic run, input logic ovf, input logic unf);
    exp_t e;
    e.pc  = pc;
    e.run = run;
    e.ovf = ovf;
    e.unf = unf;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare_next();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard: observed=empty expected=entry");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".pc"},  bus.pc,                  e.pc);
      check({t, ".run"}, {7'd0, bus.running},       {7'd0, e.run});
      check({t, ".ovf"}, {7'd0, bus.ras_overflow},  {7'd0, e.ovf});
      check({t, ".unf"}, {7'd0, bus.ras_underflow}, {7'd0, e.unf});
      $display("step %-14s pc=0x%02h running=%0b ovf=%0b unf=%0b", t, bus.pc,
               bus.running, bus.ras_overflow, bus.ras_underflow);
    end
  endtask

  task automatic clear_req();
    bus.start         = 1'b0;
    bus.start_address = '0;
    bus.branch        = 1'b0;
    bus.taken         = 1'b0;
    bus.offset        = '0;
    bus.jump          = 1'b0;
    bus.call          = 1'b0;
    bus.ret           = 1'b0;
    bus.target        = '0;
    bus.halt          = 1'b0;
  endtask

  // Queue the expectation, let one edge pass, compare, then drop all requests.
  task automatic step(input string tag, input logic [7:0] pc,
                      input logic run, input logic ovf, input logic unf);
    expect_state(tag, pc, run, ovf, unf);
    @(posedge clock);
    #1;
    compare_next();
    clear_req();
  endtask

  task automatic do_start(input logic [7:0] addr);
    bus.start         = 1'b1;
    bus.start_address = addr;
  endtask

  task automatic do_branch(input logic tk, input logic [4:0] off);
    bus.branch = 1'b1;
    bus.taken  = tk;
    bus.offset = off;
  endtask

  task automatic do_call(input logic [7:0] tgt);
    bus.call   = 1'b1;
    bus.target = tgt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_req();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    expect_state("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    compare_next();
    reset_n = 1'b1;

    // IDLE ignores everything except start
    bus.jump = 1'b1; bus.target = 8'h55;
    step("idle_jump",  8'h00, 1'b0, 1'b0, 1'b0);
    step("idle_hold",  8'h00, 1'b0, 1'b0, 1'b0);

    // reset then start
    do_start(8'h10);  step("start_10", 8'h10, 1'b1, 1'b0, 1'b0);
    step("inc_11", 8'h11, 1'b1, 1'b0, 1'b0);
    step("inc_12", 8'h12, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b0;
    #2;
    expect_state("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    compare_next();
    reset_n = 1'b1;

    // branch and wrap
    do_start(8'h12);           step("start_12",  8'h12, 1'b1, 1'b0, 1'b0);
    do_branch(1'b1, 5'h1D);    step("br_m3",     8'h0F, 1'b1, 1'b0, 1'b0);
    do_start(8'h02);           step("start_02",  8'h02, 1'b1, 1'b0, 1'b0);
    do_branch(1'b1, 5'h1B);    step("br_m5_wrap", 8'hFD, 1'b1, 1'b0, 1'b0);
    step("inc_fe", 8'hFE, 1'b1, 1'b0, 1'b0);
    step("inc_ff", 8'hFF, 1'b1, 1'b0, 1'b0);
    step("inc_wrap", 8'h00, 1'b1, 1'b0, 1'b0);
    do_branch(1'b0, 5'h1B);    step("br_not_tk", 8'h01, 1'b1, 1'b0, 1'b0);
    do_branch(1'b1, 5'h04);    step("br_p4",     8'h05, 1'b1, 1'b0, 1'b0);
    do_branch(1'b1, 5'h10);    step("br_m16",    8'hF5, 1'b1, 1'b0, 1'b0);

    // call / return
    do_start(8'h20);           step("start_20", 8'h20, 1'b1, 1'b0, 1'b0);
    do_call(8'h40);            step("call_40",  8'h40, 1'b1, 1'b0, 1'b0);
    step("inc_41", 8'h41, 1'b1, 1'b0, 1'b0);
    step("inc_42", 8'h42, 1'b1, 1'b0, 1'b0);
    step("inc_43", 8'h43, 1'b1, 1'b0, 1'b0);
    bus.ret = 1'b1;            step("ret_21",   8'h21, 1'b1, 1'b0, 1'b0);

    // call+ret together: pop only; the following ret then underflows
    do_start(8'h10);           step("start_10b", 8'h10, 1'b1, 1'b0, 1'b0);
    do_call(8'h50);            step("call_50",   8'h50, 1'b1, 1'b0, 1'b0);
    do_call(8'h77); bus.ret = 1'b1;
    step("call_ret", 8'h11, 1'b1, 1'b0, 1'b0);
    bus.ret = 1'b1;            step("ret_empty", 8'h12, 1'b1, 1'b0, 1'b1);

    // overflow / underflow
    do_start(8'h10);           step("start_clr", 8'h10, 1'b1, 1'b0, 1'b0);
    do_call(8'h30);            step("call_30",   8'h30, 1'b1, 1'b0, 1'b0);
    do_call(8'h50);            step("call_50b",  8'h50, 1'b1, 1'b0, 1'b0);
    do_call(8'h70);            step("call_70",   8'h70, 1'b1, 1'b0, 1'b0);
    do_call(8'h90);            step("call_90",   8'h90, 1'b1, 1'b0, 1'b0);
    do_call(8'hB0);            step("call_ovf",  8'hB0, 1'b1, 1'b1, 1'b0);
    bus.ret = 1'b1;            step("ret_91",    8'h91, 1'b1, 1'b1, 1'b0);
    bus.ret = 1'b1;            step("ret_71",    8'h71, 1'b1, 1'b1, 1'b0);
    bus.ret = 1'b1;            step("ret_51",    8'h51, 1'b1, 1'b1, 1'b0);
    bus.ret = 1'b1;            step("ret_31",    8'h31, 1'b1, 1'b1, 1'b0);
    bus.ret = 1'b1;            step("ret_unf",   8'h32, 1'b1, 1'b1, 1'b1);
    do_start(8'h00);           step("start_flag", 8'h00, 1'b1, 1'b0, 1'b0);

    // halt
    do_start(8'h24);           step("start_24", 8'h24, 1'b1, 1'b0, 1'b0);
    bus.halt = 1'b1;           step("halt",     8'h24, 1'b0, 1'b0, 1'b0);
    do_branch(1'b1, 5'h03); do_call(8'h99); bus.jump = 1'b1; bus.ret = 1'b1;
    step("halted_req", 8'h24, 1'b0, 1'b0, 1'b0);
    step("halted_hold", 8'h24, 1'b0, 1'b0, 1'b0);
    do_start(8'h00);           step("restart",  8'h00, 1'b1, 1'b0, 1'b0);

    // priority: jump beats taken branch and halt
    do_start(8'h08);           step("start_08", 8'h08, 1'b1, 1'b0, 1'b0);
    bus.jump = 1'b1; bus.target = 8'h80; do_branch(1'b1, 5'h04); bus.halt = 1'b1;
    step("prio_jump", 8'h80, 1'b1, 1'b0, 1'b0);
    step("prio_run",  8'h81, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
